// File: rtl/asg_sweep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | asg_sweep_pkg : shared types and clamped-step helper for the sweep   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package asg_sweep_pkg;

  localparam int STEP_W = 64;

  typedef enum logic [1:0] {
    SWP_ONCE     = 2'd0,
    SWP_REPEAT   = 2'd1,
    SWP_PINGPONG = 2'd2
  } sweep_mode_t;

  typedef enum logic {
    SWP_IDLE = 1'b0,
    SWP_RUN  = 1'b1
  } sweep_state_t;

  typedef struct packed {
    logic              reached;
    logic [STEP_W-1:0] value;
  } sweep_next_t;

  function automatic sweep_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return SWP_REPEAT;
      2'd2:    return SWP_PINGPONG;
      default: return SWP_ONCE;
    endcase
  endfunction

  // One extra bit catches both overflow (up) and underflow (down) so the
  // result clamps at the target instead of wrapping.
  function automatic sweep_next_t sweep_next(
    input logic [STEP_W-1:0] cur,
    input logic [STEP_W-1:0] target,
    input logic [STEP_W-1:0] delta,
    input logic              down
  );
    logic [STEP_W:0] sum;
    sweep_next_t     r;
    if (down) begin
      sum       = {1'b0, cur} - {1'b0, delta};
      r.reached = sum[STEP_W] || (sum[STEP_W-1:0] <= target);
    end else begin
      sum       = {1'b0, cur} + {1'b0, delta};
      r.reached = (sum >= {1'b0, target});
    end
    r.value = r.reached ? target : sum[STEP_W-1:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/asg_sweep_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | asg_sweep_tick : update-period down-counter, tick when it hits zero  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module asg_sweep_tick #(
  parameter int PER_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [PER_W-1:0] per,
  output logic             tick
);

  logic [PER_W-1:0] reload;
  logic [PER_W-1:0] count;
  logic [PER_W-1:0] per_m1;

  // A period of zero behaves like a period of one.
  assign per_m1 = (per == '0) ? '0 : per - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= '0;
      count  <= '0;
    end else if (load) begin
      reload <= per_m1;
      count  <= per_m1;
    end else if (run) begin
      count  <= (count == '0) ? reload : count - 1'b1;
    end
  end

  assign tick = run && (count == '0);

endmodule
`default_nettype wire

// File: rtl/red_pitaya_asg_sweep.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | red_pitaya_asg_sweep : ASG phase-increment frequency sweep generator |
// | Optional geometric mode under macro ASG_SWEEP_EXP_EN. Revision 1.0   |
// +----------------------------------------------------------------------+
module red_pitaya_asg_sweep #(
  parameter int STEP_W = asg_sweep_pkg::STEP_W,
  parameter int PER_W  = 32
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] cfg_start_i,
  input  logic [STEP_W-1:0] cfg_stop_i,
  input  logic [STEP_W-1:0] cfg_inc_i,
  input  logic [PER_W-1:0]  cfg_per_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic              cfg_exp_i,
  input  logic [5:0]        cfg_shift_i,
  output logic [31:0]       step_o,
  output logic [31:0]       step_lo_o,
  output logic              step_upd_o,
  output logic              busy_o,
  output logic              dir_o,
  output logic              done_o
);

  import asg_sweep_pkg::*;

  sweep_state_t      state, state_nxt;
  sweep_mode_t       mode_q;
  logic [STEP_W-1:0] start_q, stop_q, inc_q;
  logic              down_q;
  logic [STEP_W-1:0] cur, cur_nxt;
  logic              dir, dir_nxt;
  logic              wrap_pend, wrap_nxt;
  logic              upd_nxt, done_nxt;
  logic              accept, tick;
  logic [STEP_W-1:0] target, delta;
  sweep_next_t       nxt;

  assign accept = start_i && !abort_i;

  asg_sweep_tick #(.PER_W(PER_W)) u_tick (
    .clk   (dac_clk_i),
    .rst_n (dac_rstn_i),
    .load  (accept),
    .run   (state == SWP_RUN),
    .per   (cfg_per_i),
    .tick  (tick)
  );

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      mode_q  <= SWP_ONCE;
      down_q  <= 1'b0;
    end else if (accept) begin
      start_q <= cfg_start_i;
      stop_q  <= cfg_stop_i;
      inc_q   <= cfg_inc_i;
      mode_q  <= decode_mode(cfg_mode_i);
      down_q  <= (cfg_start_i > cfg_stop_i);
    end
  end

`ifdef ASG_SWEEP_EXP_EN
  logic              exp_q;
  logic [5:0]        shift_q;
  logic [STEP_W-1:0] shifted;

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      exp_q   <= 1'b0;
      shift_q <= '0;
    end else if (accept) begin
      exp_q   <= cfg_exp_i;
      shift_q <= cfg_shift_i;
    end
  end

  assign shifted = cur >> shift_q;
  assign delta   = !exp_q ? inc_q :
                   (shifted == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : shifted;
`else
  logic unused_exp;
  assign unused_exp = ^{cfg_exp_i, cfg_shift_i};
  assign delta      = inc_q;
`endif

  // dir flips the direction relative to the captured sweep sense.
  assign target = dir ? start_q : stop_q;
  assign nxt    = sweep_next(cur, target, delta, down_q ^ dir);

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    dir_nxt   = dir;
    wrap_nxt  = wrap_pend;
    upd_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (abort_i) begin
      state_nxt = SWP_IDLE;
    end else if (start_i) begin
      state_nxt = SWP_RUN;
      cur_nxt   = cfg_start_i;
      dir_nxt   = 1'b0;
      wrap_nxt  = 1'b0;
      upd_nxt   = 1'b1;
    end else if (state == SWP_RUN && tick) begin
      if (wrap_pend) begin
        cur_nxt  = start_q;
        wrap_nxt = 1'b0;
        upd_nxt  = (cur != start_q);
      end else begin
        cur_nxt = nxt.value;
        upd_nxt = (nxt.value != cur);
        if (nxt.reached) begin
          case (mode_q)
            SWP_REPEAT:   wrap_nxt = 1'b1;
            SWP_PINGPONG: dir_nxt  = ~dir;
            default: begin
              state_nxt = SWP_IDLE;
              done_nxt  = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state      <= SWP_IDLE;
      cur        <= '0;
      dir        <= 1'b0;
      wrap_pend  <= 1'b0;
      step_upd_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      dir        <= dir_nxt;
      wrap_pend  <= wrap_nxt;
      step_upd_o <= upd_nxt;
      done_o     <= done_nxt;
    end
  end

  assign step_o    = cur[STEP_W-1:32];
  assign step_lo_o = cur[31:0];
  assign busy_o    = (state == SWP_RUN);
  assign dir_o     = dir;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_asg_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for red_pitaya_asg_sweep: directed table, corner
// sequences, and randomized sweeps against a list-of-visited-values model.
module tb_red_pitaya_asg_sweep;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] cfg_start = '0, cfg_stop = '0, cfg_inc = '0;
  logic [31:0] cfg_per = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_exp = 1'b0;
  logic [5:0]  cfg_shift = '0;
  logic [31:0] step_hi, step_lo;
  logic        step_upd, busy, dir, done;
  logic [63:0] step_full;

  assign step_full = {step_hi, step_lo};

  always #5 clk = ~clk;

  red_pitaya_asg_sweep dut (
    .dac_clk_i   (clk),
    .dac_rstn_i  (rstn),
    .start_i     (start),
    .abort_i     (abort),
    .cfg_start_i (cfg_start),
    .cfg_stop_i  (cfg_stop),
    .cfg_inc_i   (cfg_inc),
    .cfg_per_i   (cfg_per),
    .cfg_mode_i  (cfg_mode),
    .cfg_exp_i   (cfg_exp),
    .cfg_shift_i (cfg_shift),
    .step_o      (step_hi),
    .step_lo_o   (step_lo),
    .step_upd_o  (step_upd),
    .busy_o      (busy),
    .dir_o       (dir),
    .done_o      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [63:0] s, input logic [63:0] p, input logic [63:0] i,
                         input logic [31:0] per, input logic [1:0] m);
    cfg_start = s; cfg_stop = p; cfg_inc = i; cfg_per = per; cfg_mode = m;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  // Directed vectors: config plus the value/dir seen at each update.
  typedef struct packed {
    logic [63:0]      s, p, i;
    logic [31:0]      per;
    logic [1:0]       mode;
    logic [3:0]       n;
    logic             done_last;
    logic [7:0]       ed;
    logic [7:0][63:0] ev;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  task automatic mk(input int k, input logic [63:0] s, input logic [63:0] p, input logic [63:0] i,
                    input logic [31:0] per, input logic [1:0] mode, input int n, input logic dl,
                    input logic [7:0] ed, input logic [63:0] e0, input logic [63:0] e1,
                    input logic [63:0] e2, input logic [63:0] e3, input logic [63:0] e4,
                    input logic [63:0] e5, input logic [63:0] e6, input logic [63:0] e7);
    vt[k].s = s; vt[k].p = p; vt[k].i = i; vt[k].per = per; vt[k].mode = mode;
    vt[k].n = 4'(n); vt[k].done_last = dl; vt[k].ed = ed;
    vt[k].ev[0] = e0; vt[k].ev[1] = e1; vt[k].ev[2] = e2; vt[k].ev[3] = e3;
    vt[k].ev[4] = e4; vt[k].ev[5] = e5; vt[k].ev[6] = e6; vt[k].ev[7] = e7;
  endtask

  // Reference model: list of values visited at successive updates.
  logic [63:0] mv[$];
  logic        md[$];
  int          fin;

  task automatic build_model(input logic [63:0] s, input logic [63:0] p, input logic [63:0] i,
                             input logic [1:0] mode, input int u_max);
    logic [63:0] cur, tgt;
    logic [64:0] t;
    logic        d, wrap, reached;
    mv.delete(); md.delete();
    fin = -1; cur = s; d = 1'b0; wrap = 1'b0;
    mv.push_back(s); md.push_back(1'b0);
    while (mv.size() < u_max && fin < 0) begin
      if (wrap) begin
        cur = s; wrap = 1'b0;
      end else begin
        tgt = d ? s : p;
        if (cur < tgt) begin
          t = {1'b0, cur} + {1'b0, i};
          reached = (t >= {1'b0, tgt});
          if (!reached) cur = t[63:0];
        end else if (cur > tgt) begin
          reached = (i >= cur) || (cur - i <= tgt);
          if (!reached) cur = cur - i;
        end else begin
          reached = 1'b1;
        end
        if (reached) begin
          cur = tgt;
          if (mode == 2'd1) wrap = 1'b1;
          else if (mode == 2'd2) d = ~d;
          else fin = mv.size();
        end
      end
      mv.push_back(cur); md.push_back(d);
    end
  endtask

  initial begin
    int          p_eff, last;
    logic        dl, exp_upd;
    logic [63:0] ex[$];

    mk(0, 64'h1_0000_0000, 64'h5_0000_0000, 64'h1_0000_0000, 4, 0, 5, 1, 8'h00,
       64'h1_0000_0000, 64'h2_0000_0000, 64'h3_0000_0000, 64'h4_0000_0000, 64'h5_0000_0000, 0, 0, 0);
    mk(1, 0, 10, 4, 1, 0, 4, 1, 8'h00, 0, 4, 8, 10, 0, 0, 0, 0);
    mk(2, 100, 90, 5, 2, 2, 7, 0, 8'b0100_1100, 100, 95, 90, 95, 100, 95, 90, 0);
    mk(3, 0, 2, 1, 0, 1, 7, 0, 8'h00, 0, 1, 2, 0, 1, 2, 0, 0);
    mk(4, 7, 7, 3, 3, 0, 2, 1, 8'h00, 7, 7, 0, 0, 0, 0, 0, 0);
    mk(5, 5, 9, 0, 1, 0, 4, 0, 8'h00, 5, 5, 5, 5, 0, 0, 0, 0);
    mk(6, 0, 3, 2, 1, 3, 3, 1, 8'h00, 0, 2, 3, 0, 0, 0, 0, 0);
    mk(7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h8000_0000_0000_0000, 2, 0, 3, 1, 8'h00,
       64'hFFFF_FFFF_FFFF_FFF0, 64'h7FFF_FFFF_FFFF_FFF0, 64'h10, 0, 0, 0, 0, 0);
    mk(8, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h80, 1, 0, 3, 1, 8'h00,
       64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);

    // Reset values (checked while reset is asserted).
    #12;
    chk("rst_step", step_full, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_upd", step_upd, 1'b0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_done", done, 1'b0);
    cyc();
    rstn = 1'b1;
    cyc();

    // Directed table.
    for (int v = 0; v < NV; v++) begin
      set_cfg(vt[v].s, vt[v].p, vt[v].i, vt[v].per, vt[v].mode);
      pulse_start();
      p_eff = (vt[v].per == 0) ? 1 : int'(vt[v].per);
      last  = int'(vt[v].n) - 1;
      for (int j = 0; j <= last; j++) begin
        if (j > 0) begin
          for (int w = 1; w < p_eff; w++) begin
            cyc();
            chk("tbl_gap_upd", step_upd, 1'b0);
          end
          cyc();
        end
        dl      = vt[v].done_last && (j == last);
        exp_upd = (j == 0) || (vt[v].ev[j] != vt[v].ev[j-1]);
        chk($sformatf("tbl%0d_val%0d", v, j), step_full, vt[v].ev[j]);
        chk($sformatf("tbl%0d_dir%0d", v, j), dir, vt[v].ed[j]);
        chk($sformatf("tbl%0d_upd%0d", v, j), step_upd, exp_upd);
        chk($sformatf("tbl%0d_done%0d", v, j), done, dl);
        chk($sformatf("tbl%0d_busy%0d", v, j), busy, !dl);
      end
      do_abort();
      chk("tbl_abort_busy", busy, 1'b0);
      chk("tbl_abort_done", done, 1'b0);
    end

    // Abort together with start mid-run: abort wins, step holds.
    set_cfg(0, 100, 10, 1, 0);
    pulse_start();
    cyc(); cyc();
    chk("ab_pre", step_full, 64'd20);
    set_cfg(500, 600, 1, 3, 0);
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_hold", step_full, 64'd20);
    chk("ab_upd", step_upd, 1'b0);
    chk("ab_done", done, 1'b0);
    cyc();
    chk("ab_hold2", step_full, 64'd20);
    chk("ab_done2", done, 1'b0);
    pulse_start();
    chk("ab_restart_val", step_full, 64'd500);
    chk("ab_restart_upd", step_upd, 1'b1);
    chk("ab_restart_busy", busy, 1'b1);
    cyc();
    chk("ab_restart_upd_off", step_upd, 1'b0);
    do_abort();

    // Start while running is a full restart.
    set_cfg(0, 100, 10, 1, 0);
    pulse_start();
    cyc();
    chk("rs_pre", step_full, 64'd10);
    set_cfg(50, 60, 5, 1, 0);
    pulse_start();
    chk("rs_val0", step_full, 64'd50);
    chk("rs_upd0", step_upd, 1'b1);
    cyc();
    chk("rs_val1", step_full, 64'd55);
    cyc();
    chk("rs_val2", step_full, 64'd60);
    chk("rs_done", done, 1'b1);
    chk("rs_busy", busy, 1'b0);

    // Reset mid-run after dir has flipped.
    set_cfg(0, 100, 50, 1, 2);
    pulse_start();
    cyc(); cyc();
    chk("mr_dir_pre", dir, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mr_step", step_full, 64'h0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_dir", dir, 1'b0);
    cyc();
    rstn = 1'b1;
    cyc(); cyc();
    chk("mr_idle", busy, 1'b0);

    // Exponential request: geometric with macro, ignored without.
    set_cfg(8, 30, 5, 1, 0);
    cfg_exp = 1'b1; cfg_shift = 6'd1;
`ifdef ASG_SWEEP_EXP_EN
    ex = '{64'd8, 64'd12, 64'd18, 64'd27, 64'd30};
`else
    ex = '{64'd8, 64'd13, 64'd18, 64'd23, 64'd28, 64'd30};
`endif
    pulse_start();
    for (int j = 0; j < ex.size(); j++) begin
      if (j > 0) cyc();
      chk($sformatf("exp_val%0d", j), step_full, ex[j]);
      chk($sformatf("exp_done%0d", j), done, j == ex.size() - 1);
    end
    cfg_exp = 1'b0; cfg_shift = '0;
    cyc();

    // Randomized sweeps against the model; cfg inputs scrambled after start.
    for (int it = 0; it < 25; it++) begin
      logic [63:0] rs, rp, ri;
      logic [31:0] rper;
      logic [1:0]  rmode;
      int          u, r, ui, cyc_n;
      rs = 64'($urandom_range(0, 200));
      rp = 64'($urandom_range(0, 200));
      ri = (($urandom_range(0, 7)) == 0) ? 64'd0 : 64'($urandom_range(1, 60));
      if ($urandom_range(0, 3) == 0) begin
        rs[63:32] = $urandom;
        rp[63:32] = $urandom;
        ri = {32'($urandom_range(0, 3)), $urandom};
      end
      rper  = 32'($urandom_range(0, 3));
      rmode = 2'($urandom_range(0, 3));
      cyc_n = 30;
      set_cfg(rs, rp, ri, rper, rmode);
`ifndef ASG_SWEEP_EXP_EN
      cfg_exp = 1'($urandom); cfg_shift = 6'($urandom);
`endif
      build_model(rs, rp, ri, rmode, cyc_n + 2);
      p_eff = (rper == 0) ? 1 : int'(rper);
      start = 1'b1;
      cyc();
      start = 1'b0;
      set_cfg({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              32'($urandom_range(0, 5)), 2'($urandom));
      for (int k = 1; k <= cyc_n; k++) begin
        if (k > 1) cyc();
        u  = (k - 1) / p_eff;
        r  = (k - 1) % p_eff;
        ui = (fin >= 0 && u > fin) ? fin : u;
        exp_upd = (r == 0) && (fin < 0 || u <= fin) && (u == 0 || mv[u] != mv[u-1]);
        chk("rnd_val", step_full, mv[ui]);
        chk("rnd_dir", dir, md[ui]);
        chk("rnd_upd", step_upd, exp_upd);
        chk("rnd_done", done, (r == 0) && (u == fin));
        chk("rnd_busy", busy, !(fin >= 0 && u >= fin));
      end
      do_abort();
      chk("rnd_abort_busy", busy, 1'b0);
    end
    cfg_exp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
